// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: starts on `start`, advances/branches/stalls the PC,
// and parks in DONE once the halt opcode is fetched.
module fetch_sequencer #(
   parameter int          ADDR_BITS   = 12,
   parameter logic [31:0] START_PC    = 32'd0,
   parameter logic [8:0]  HALT_OPCODE = 9'b111111111
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [8:0]  instruction,
   output logic [31:0] current_pc,
   output logic        instr_valid,
   output logic        busy,
   output logic        done,
   output logic [31:0] cycle_count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [ADDR_BITS-1:0] START_A = START_PC[ADDR_BITS-1:0];

   state_t               state_q;
   logic [ADDR_BITS-1:0] pc_q, pc_d;
   logic [31:0]          cnt_q, cnt_d;
   logic                 busy_q, done_q;
   logic                 halt_fetch;
   logic                 unused_tgt_hi;

   assign unused_tgt_hi = ^branch_target[31:ADDR_BITS];
   assign halt_fetch    = !stall && (instruction == HALT_OPCODE);

   // Halt outranks branch; the PC stays parked on the halt address.
   always_comb begin
      pc_d = pc_q;
      if (!stall && !halt_fetch) begin
         pc_d = branch_taken ? branch_target[ADDR_BITS-1:0] : pc_q + ADDR_BITS'(1);
      end
      cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= START_A;
         cnt_q   <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q <= RUN;
                  pc_q    <= START_A;
                  cnt_q   <= 32'd0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            RUN: begin
               cnt_q <= cnt_d;
               pc_q  <= pc_d;
               if (halt_fetch) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign current_pc  = 32'(pc_q);
   assign instr_valid = busy_q & ~stall;
   assign busy        = busy_q;
   assign done        = done_q;
   assign cycle_count = cnt_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter sequencer that owns `current_pc` for the instruction memory. It starts program execution on a `start` pulse, advances the PC or redirects it on branches, and holds on stalls. It detects the halt opcode on the fetched 9-bit instruction, then parks in a done state. It sits between the top-level testbench/control handshake and the instruction memory, and feeds `instr_valid` to the decode stage.

## Interface
- `ADDR_BITS`, 12: number of significant PC bits (instruction memory depth is 2^ADDR_BITS).
- `START_PC`, 0: PC loaded on reset and on every accepted `start`; must be < 2^ADDR_BITS.
- `HALT_OPCODE`, 9'b111111111: instruction encoding that terminates the program.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; forces the IDLE state immediately.
- `start`  in  1  level sampled each edge; begins a program from IDLE or DONE.
- `stall`  in  1  holds PC this cycle (datapath busy).
- `branch_taken`  in  1  redirect request from execute.
- `branch_target`  in  32  redirect address; only bits [ADDR_BITS-1:0] are used.
- `instruction`  in  9  instruction memory read data for `current_pc`.
- `current_pc`  out  32  registered PC to instruction memory; bits above ADDR_BITS are always 0.
- `instr_valid`  out  1  `instruction` is to be executed this cycle.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE; registered.
- `cycle_count`  out  32  RUN cycles of the current/last program.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, `current_pc`=START_PC, `cycle_count`=0, `done`=0, `busy`=0, `instr_valid`=0.
- IDLE:
  - `start`=1 → RUN; `current_pc`←START_PC; `cycle_count`←0.
  - Otherwise hold.
- RUN: `busy`=1 and `instr_valid`=!`stall`. Each edge, first match wins:
  1. `stall`=1: PC holds and the state is unchanged.
  2. `instruction`==HALT_OPCODE: → DONE, PC holds at the halt address. Halt beats `branch_taken`.
  3. `branch_taken`=1: PC←{0, `branch_target`[ADDR_BITS-1:0]}.
  4. Otherwise PC←(PC+1) mod 2^ADDR_BITS. PC 2^ADDR_BITS−1 wraps to 0.
  - `start` is ignored in RUN.
- DONE:
  - `done`=1 and `busy`=0; PC and `cycle_count` frozen.
  - `start`=1 → RUN with PC←START_PC, `cycle_count`←0, and `done` clears on that edge.
- `cycle_count`:
  - Increments on every edge taken in RUN, including stalled cycles and the halting cycle.
  - Saturates at 32'hFFFF_FFFF with no wrap.
  - The load to 0 on `start` takes precedence.
- A stalled halt instruction is not acted on until `stall` drops.
- `reset` asserted at any time, including mid-RUN or mid-stall, returns all state to reset values asynchronously. The program does not resume; a new `start` is required after `reset` deasserts.

## Timing
- `start` high at edge t → RUN from cycle t+1. `current_pc`=START_PC and `instr_valid`=1 in cycle t+1.
- Instruction memory is combinational, so the instruction at `current_pc` is valid in the same cycle. Zero-bubble fetch: one instruction per non-stalled RUN cycle.
- Branch sampled at edge e → target PC visible in cycle e+1 with no bubble. Squashing wrong-path work is the datapath's responsibility.
- Halt fetched in cycle k (not stalled) → `done`=1 and `busy`=0 from cycle k+1. `cycle_count` includes cycle k.
- `reset` deassertion: the first edge after deassertion can accept `start`.

## Test plan
- Straight line: memory 0–4 = non-halt, 5 = HALT; pulse `start` → PC sequence 0,1,2,3,4,5 on consecutive cycles, then `done`=1, `current_pc`=5, `cycle_count`=6, `busy`=0.
- Branch: `branch_taken`=1 with target 0x10 while PC=2 → next PC=0x10. `branch_taken` with a HALT fetched → DONE and PC unchanged.
- Stall: `stall` held 3 cycles at PC=3 → PC stays 3, `instr_valid`=0 for those cycles, `cycle_count` advances by 3. Stall over a HALT → DONE only on the first unstalled cycle.
- Wrap/truncation: branch to 4095 then non-halt → PC=0. Branch target 0x0001_2005 → `current_pc`=0x0000_0005.
- Async reset mid-RUN at PC=7, asserted between edges → `current_pc`=0, `busy`=0, `cycle_count`=0 before the next edge. `start` ignored while `reset`=1.
- Restart: from DONE, pulse `start` → `done` drops, PC=0, `cycle_count` restarts at 0. `start` asserted mid-RUN has no effect on PC.
